// File: rtl/pin_brute_ctrl.sv
// pin_brute_ctrl: PIN brute-force sequencer for a serial target.
// Waits for the PIN prompt, streams the current candidate as ASCII (least
// significant digit first, optional CR), then decides on the outcome:
// a rejection advances the candidate and pulses the target reset, and a
// silent timeout means the PIN was accepted.
module pin_brute_ctrl #(
  parameter int         NUM_DIGITS     = 4,
  parameter int         DIGIT_MAX      = 9,
  parameter logic [7:0] ASCII_BASE     = 8'h30,
  parameter int         SEND_CR        = 1,
  parameter int         RST_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    prompt_seen,
  input  logic                    invalid_seen,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    target_rst,
  output logic                    busy,
  output logic                    found,
  output logic                    exhausted,
  output logic [8*NUM_DIGITS-1:0] pin_out,
  output logic [31:0]             attempt_count
);

  typedef enum logic [2:0] {
    IDLE, WAIT_PROMPT, SEND, WAIT_RESULT, RESET_TGT, DONE
  } state_t;

  localparam int          NUM_BYTES    = NUM_DIGITS + ((SEND_CR != 0) ? 1 : 0);
  localparam logic [3:0]  LAST_BYTE    = 4'(NUM_BYTES - 1);
  localparam logic [7:0]  DIGIT_TOP    = 8'(DIGIT_MAX);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);

  state_t                     state_q, state_d;
  logic [NUM_DIGITS-1:0][7:0] digit_q, digit_d, digit_inc;
  logic [3:0]                 byte_idx_q, byte_idx_d;
  logic [31:0]                timer_q, timer_d;
  logic [31:0]                rst_cnt_q, rst_cnt_d;
  logic                       found_q, found_d;
  logic                       exhausted_q, exhausted_d;
  logic [31:0]                attempt_q, attempt_d;
  logic [NUM_DIGITS-1:0]      at_top;
  logic [NUM_DIGITS-1:0]      carry;
  logic                       all_top;

  // Mixed-radix ripple incrementer: digit 0 always counts, a digit at its
  // top value wraps and passes the carry upward, all in one cycle.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign at_top[gi]         = (digit_q[gi] == DIGIT_TOP);
      assign digit_inc[gi]      = !carry[gi] ? digit_q[gi]
                                : (at_top[gi] ? 8'd0 : digit_q[gi] + 8'd1);
      assign pin_out[8*gi +: 8] = ASCII_BASE + digit_q[gi];
      if (gi < NUM_DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] & at_top[gi];
      end
    end
  endgenerate
  assign all_top = &at_top;

  // Byte being offered: a digit while the index is inside the PIN, else CR.
  // Only registers feed it, so it cannot move while a byte is stalled.
  always_comb begin
    tx_data = 8'h0D;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (byte_idx_q == 4'(i)) tx_data = ASCII_BASE + digit_q[i];
    end
  end

  assign tx_valid      = (state_q == SEND);
  assign target_rst    = (state_q == RESET_TGT);
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign found         = found_q;
  assign exhausted     = exhausted_q;
  assign attempt_count = attempt_q;

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      digit_q     <= '0;
      byte_idx_q  <= '0;
      timer_q     <= '0;
      rst_cnt_q   <= '0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      attempt_q   <= '0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      byte_idx_q  <= byte_idx_d;
      timer_q     <= timer_d;
      rst_cnt_q   <= rst_cnt_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
      attempt_q   <= attempt_d;
    end
  end

  // Next-state logic: every register holds unless its state acts on it.
  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    byte_idx_d  = byte_idx_q;
    timer_d     = timer_q;
    rst_cnt_d   = rst_cnt_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    attempt_d   = attempt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          digit_d     = '0;
          found_d     = 1'b0;
          exhausted_d = 1'b0;
          attempt_d   = '0;
          byte_idx_d  = '0;
          state_d     = WAIT_PROMPT;
        end
      end
      WAIT_PROMPT: begin
        if (prompt_seen) begin
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            timer_d    = '0;
            attempt_d  = (attempt_q == 32'hFFFF_FFFF) ? attempt_q : attempt_q + 32'd1;
            state_d    = WAIT_RESULT;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end
      end
      WAIT_RESULT: begin
        // A rejection outranks a timeout landing in the same cycle.
        if (invalid_seen) begin
          if (all_top) begin
            exhausted_d = 1'b1;
            state_d     = DONE;
          end else begin
            digit_d   = digit_inc;
            rst_cnt_d = '0;
            state_d   = RESET_TGT;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          found_d = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      RESET_TGT: begin
        if (rst_cnt_q == RST_LAST) state_d = WAIT_PROMPT;
        else                       rst_cnt_d = rst_cnt_q + 32'd1;
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/pin_brute_ctrl.md
PIN_BRUTE_CTRL -- requirements
Module: pin_brute_ctrl

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4: number of PIN digits per attempt (1..8).
REQ-002 SHALL provide parameter DIGIT_MAX, default 9: highest digit value; each digit counts 0..DIGIT_MAX.
REQ-003 SHALL provide parameter ASCII_BASE, default 8'h30: byte sent for digit value 0.
REQ-004 SHALL provide parameter SEND_CR, default 1: when 1, append byte 8'h0D after the digits.
REQ-005 SHALL provide parameter RST_CYCLES, default 16: width of the target reset pulse, in cycles (>=1).
REQ-006 SHALL provide parameter TIMEOUT_CYCLES, default 1000000: idle cycles after a send that mean success (>=2).
REQ-007 SHALL have one clock; reset is synchronous and active-high.
REQ-008 Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a run.
- prompt_seen  in  1  one-cycle pulse: target printed its PIN prompt.
- invalid_seen  in  1  one-cycle pulse: target rejected the PIN.
- tx_ready  in  1  byte transmitter can accept a byte.
- tx_valid  out  1  tx_data holds a byte to transmit.
- tx_data  out  8  byte to transmit.
- target_rst  out  1  reset drive to the target board.
- busy  out  1  run in progress.
- found  out  1  sticky: the PIN was accepted.
- exhausted  out  1  sticky: every combination was rejected.
- pin_out  out  8*NUM_DIGITS  current candidate as ASCII; byte 0 = least-significant digit.
- attempt_count  out  32  number of completed PIN sends.

Function
REQ-009 States SHALL be IDLE, WAIT_PROMPT, SEND, WAIT_RESULT, RESET_TGT, DONE.
REQ-010 IDLE: a start pulse SHALL clear all digits to 0, clear found, exhausted and attempt_count, and enter WAIT_PROMPT; start SHALL be ignored in every other state.
REQ-011 WAIT_PROMPT: a prompt_seen pulse SHALL enter SEND with the byte index set to 0.
REQ-012 SEND: tx_valid SHALL be 1. Bytes SHALL be digit 0 first, through digit NUM_DIGITS-1, then 8'h0D if SEND_CR=1. Each byte value SHALL be ASCII_BASE + digit.
REQ-013 A byte SHALL transfer in any cycle with tx_valid=1 and tx_ready=1. tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-014 After the last byte transfers, the next cycle SHALL be WAIT_RESULT with the timeout counter at 0, tx_valid=0, and attempt_count incremented by 1.
REQ-015 WAIT_RESULT, invalid_seen=1: the block SHALL advance the candidate by one and enter RESET_TGT, unless the candidate is all DIGIT_MAX; in that case it SHALL enter DONE with exhausted=1.
REQ-016 WAIT_RESULT, no invalid_seen for TIMEOUT_CYCLES consecutive cycles: the block SHALL enter DONE with found=1; pin_out SHALL keep the accepted PIN.
REQ-017 When invalid_seen and timeout expiry occur in the same cycle, invalid_seen SHALL take precedence.
REQ-018 Increment SHALL be mixed-radix in one cycle. Digit 0 increments. A digit at DIGIT_MAX wraps to 0 and carries into the next digit.
REQ-019 RESET_TGT: target_rst SHALL be 1 for exactly RST_CYCLES cycles, starting the cycle after invalid_seen is sampled; the block SHALL then enter WAIT_PROMPT.
REQ-020 The following SHALL be ignored: prompt_seen outside WAIT_PROMPT, and invalid_seen outside WAIT_RESULT.
REQ-021 DONE SHALL hold all outputs until rst. busy SHALL be 1 in every state except IDLE and DONE.
REQ-022 attempt_count SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-023 rst=1 SHALL force IDLE, all digits to 0, tx_valid=0, target_rst=0, busy=0, found=0, exhausted=0 and attempt_count=0, regardless of state. This includes mid-SEND and mid-RESET_TGT.
REQ-024 tx_data SHALL reset to ASCII_BASE. pin_out SHALL reset to ASCII_BASE in every byte.

Verification
REQ-025 Default parameters, tx_ready=1: start, then prompt_seen. Required: tx_data sequence 30,30,30,30,0D over five consecutive cycles; attempt_count=1.
REQ-026 Candidate 0009, then invalid_seen. Required: next candidate 0010, with pin_out = 30,31,30,30 for bytes 0..3 (least-significant first); target_rst high for exactly 16 cycles.
REQ-027 tx_ready toggling 1,0,0,1 during SEND. Required: tx_data held stable through the stalls; no byte dropped or duplicated.
REQ-028 TIMEOUT_CYCLES=10, no invalid_seen after the send. Required: found=1 ten cycles after the last byte; busy=0; pin_out unchanged.
REQ-029 NUM_DIGITS=2, DIGIT_MAX=1, invalid_seen after every send. Required: 4 attempts, then exhausted=1 with attempt_count=4. A separate case drives invalid_seen coincident with timeout expiry: required result is the invalid path.
REQ-030 rst asserted during RESET_TGT and during SEND. Required: next cycle target_rst=0, tx_valid=0, busy=0, IDLE.
